// File: rtl/pulse_interval_gen.sv
// pulse_interval_gen: emits one enable pulse lasting dur prescaled ticks.
// Two-process FSM; every output comes straight from a flop.
module pulse_interval_gen #(
  parameter int unsigned WIDTH    = 13,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dur,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining
);

  localparam int unsigned PW = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] CNT_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] rem_nxt;
  logic             en_nxt, busy_nxt, done_nxt;

  // State, prescaler and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      remaining <= '0;
      en        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      remaining <= rem_nxt;
      en        <= en_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // Next state and next output values
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rem_nxt   = remaining;
    en_nxt    = en;
    busy_nxt  = busy;
    done_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        en_nxt   = 1'b0;
        busy_nxt = 1'b0;
        rem_nxt  = '0;
        cnt_nxt  = '0;
        if (start && !abort) begin
          busy_nxt = 1'b1;
          if (dur != '0) begin
            rem_nxt   = dur;
            en_nxt    = 1'b1;
            state_nxt = RUN;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end
        end
      end

      RUN: begin
        if (abort) begin
          en_nxt    = 1'b0;
          busy_nxt  = 1'b0;
          rem_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt >= CNT_LAST) begin
          // Tick: the last one ends the pulse; <= 1 keeps remaining from wrapping
          cnt_nxt = '0;
          if (remaining <= WIDTH'(1)) begin
            rem_nxt   = '0;
            en_nxt    = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end else begin
            rem_nxt = remaining - WIDTH'(1);
          end
        end else begin
          cnt_nxt = cnt + PW'(1);
        end
      end

      DONE: begin
        en_nxt    = 1'b0;
        busy_nxt  = 1'b0;
        rem_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end

      default: begin
        en_nxt    = 1'b0;
        busy_nxt  = 1'b0;
        rem_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
